// File: rtl/fc1_weight_feeder.sv
// Weight-side partner of the FC1/FC2 engine: streams FC1 weight groups from a
// single-port SRAM onto the engine lanes and preloads the FC2 weight vector.
module fc1_weight_feeder #(
  parameter int IN1_N  = 132,
  parameter int OUT1_M = 10,
  parameter int NUM_PE = 4,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    wmem_rd_en,
  output logic [ADDR_W-1:0]       wmem_addr,
  input  logic [8*NUM_PE-1:0]     wmem_rdata,
  output logic signed [7:0]       fc1_w [0:NUM_PE-1],
  input  logic                    fc1_valid,
  output logic                    fc1_next,
  input  logic                    hold_next,
  output logic signed [7:0]       fc2_w [0:OUT1_M-1],
  output logic                    busy,
  output logic [1:0]              group_idx,
  output logic                    proto_err
);

  localparam int G     = (OUT1_M + NUM_PE - 1) / NUM_PE;
  localparam int G2    = (OUT1_M + NUM_PE - 1) / NUM_PE;
  localparam int CNT_W = $clog2(IN1_N + 2);
  localparam logic [ADDR_W-1:0] FC2_BASE = ADDR_W'(G * IN1_N);
  localparam logic [1:0]        LAST_G   = 2'(G - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_STREAM     = 3'd1,
    S_WAIT_VALID = 3'd2,
    S_NEXT       = 3'd3,
    S_FC2_LOAD   = 3'd4,
    S_WAIT_END   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          group_q, group_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                is_fc2_q, is_fc2_d;
  logic                rd_fc1_q, rd_fc1_d;
  logic                rd_fc2_q, rd_fc2_d;
  logic [CNT_W-1:0]    rd_j_q, rd_j_d;
  logic                busy_q, busy_d;
  logic                perr_q, perr_d;
  logic signed [7:0]   fc2_q [0:OUT1_M-1];
  logic signed [7:0]   fc2_d [0:OUT1_M-1];

  // Control FSM: next state, read issue and the combinational release pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    group_d  = group_q;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    is_fc2_d = is_fc2_q;
    fc1_next = 1'b0;
    perr_d   = perr_q | (fc1_valid & (state_q != S_WAIT_VALID));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          group_d  = 2'd0;
          state_d  = S_STREAM;
          rd_en_d  = 1'b1;
          addr_d   = {ADDR_W{1'b0}};
          cnt_d    = CNT_W'(1);
          is_fc2_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (cnt_q < CNT_W'(IN1_N)) begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_WAIT_VALID;
        end
      end
      S_WAIT_VALID: begin
        if (fc1_valid) begin
          if (group_q < LAST_G) begin
            state_d = S_NEXT;
          end else begin
            state_d  = S_FC2_LOAD;
            rd_en_d  = 1'b1;
            addr_d   = FC2_BASE;
            cnt_d    = CNT_W'(1);
            is_fc2_d = 1'b1;
          end
        end else begin
          state_d = S_WAIT_VALID;
        end
      end
      S_NEXT: begin
        if (!hold_next) begin
          fc1_next = 1'b1;
          if (group_q == LAST_G) begin
            state_d = S_WAIT_END;
          end else begin
            group_d  = group_q + 2'd1;
            state_d  = S_STREAM;
            rd_en_d  = 1'b1;
            addr_d   = ADDR_W'(IN1_N) * {{(ADDR_W-2){1'b0}}, group_d};
            cnt_d    = CNT_W'(1);
            is_fc2_d = 1'b0;
          end
        end else begin
          state_d = S_NEXT;
        end
      end
      S_FC2_LOAD: begin
        // One extra cycle after the last read so fc2_w is settled before release.
        if (cnt_q < CNT_W'(G2)) begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (cnt_q == CNT_W'(G2)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WAIT_END: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_END;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Read-data pipeline: tag the returning word and capture FC2 lanes.
  always_comb begin
    rd_fc1_d = rd_en_q & ~is_fc2_q;
    rd_fc2_d = rd_en_q & is_fc2_q;
    rd_j_d   = cnt_q - CNT_W'(1);
    for (int m = 0; m < OUT1_M; m++) begin
      if (rd_fc2_q && (rd_j_q == CNT_W'(m / NUM_PE))) begin
        fc2_d[m] = $signed(wmem_rdata[8*(m % NUM_PE) +: 8]);
      end else begin
        fc2_d[m] = fc2_q[m];
      end
    end
    for (int k = 0; k < NUM_PE; k++) begin
      if (rd_fc1_q) begin
        fc1_w[k] = $signed(wmem_rdata[8*k +: 8]);
      end else begin
        fc1_w[k] = 8'sd0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      group_q  <= 2'd0;
      rd_en_q  <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      is_fc2_q <= 1'b0;
      rd_fc1_q <= 1'b0;
      rd_fc2_q <= 1'b0;
      rd_j_q   <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      perr_q   <= 1'b0;
      for (int m = 0; m < OUT1_M; m++) fc2_q[m] <= 8'sd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      group_q  <= group_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      is_fc2_q <= is_fc2_d;
      rd_fc1_q <= rd_fc1_d;
      rd_fc2_q <= rd_fc2_d;
      rd_j_q   <= rd_j_d;
      busy_q   <= busy_d;
      perr_q   <= perr_d;
      for (int m = 0; m < OUT1_M; m++) fc2_q[m] <= fc2_d[m];
    end
  end

  assign wmem_rd_en = rd_en_q;
  assign wmem_addr  = addr_q;
  assign busy       = busy_q;
  assign group_idx  = group_q;
  assign proto_err  = perr_q;
  assign fc2_w      = fc2_q;

endmodule

// File: tb/tb_fc1_weight_feeder.sv
// Scoreboard bench for fc1_weight_feeder: SRAM model, engine-side valid/hold
// driver, and queues of expected reads, lane data and release pulses.
module tb_fc1_weight_feeder;

  localparam int IN1_N = 132, OUT1_M = 10, NUM_PE = 4, ADDR_W = 10;
  localparam int FC2_A = 3 * IN1_N;

  logic                clk = 1'b0;
  logic                rst_n, start, fc1_valid, hold_next;
  logic                wmem_rd_en, fc1_next, busy, proto_err;
  logic [ADDR_W-1:0]   wmem_addr;
  logic [31:0]         wmem_rdata = 32'd0;
  logic signed [7:0]   fc1_w [0:NUM_PE-1];
  logic signed [7:0]   fc2_w [0:OUT1_M-1];
  logic [1:0]          group_idx;

  typedef struct { int cyc; int val; } ev_t;
  ev_t rd_q[$];
  ev_t w_q[$];
  int  nx_q[$];

  int total = 0, bad = 0, cyc = 0;
  bit perr_exp = 1'b0;
  bit prev_next = 1'b0;
  ev_t e;
  int  np;
  logic [31:0] act_w;

  fc1_weight_feeder #(.IN1_N(IN1_N), .OUT1_M(OUT1_M), .NUM_PE(NUM_PE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata),
    .fc1_w(fc1_w), .fc1_valid(fc1_valid), .fc1_next(fc1_next), .hold_next(hold_next),
    .fc2_w(fc2_w), .busy(busy), .group_idx(group_idx), .proto_err(proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input int a);
    logic [31:0] w = 32'd0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (a < FC2_A)          w[8*k +: 8] = 8'((a + k) % 128);
      else if (a < FC2_A + 3) w[8*k +: 8] = 8'((a - FC2_A) * NUM_PE + k + 1);
      else                    w[8*k +: 8] = 8'd0;
    end
    return w;
  endfunction

  // Single-port SRAM, one-cycle read latency.
  always @(posedge clk) if (wmem_rd_en) wmem_rdata <= mem_word(int'(wmem_addr));

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Output monitor: lane data every cycle, reads and release pulses as they occur.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NUM_PE; k++) act_w[8*k +: 8] = fc1_w[k];
      if (w_q.size() > 0 && w_q[0].cyc == cyc) begin
        e = w_q.pop_front();
        check_val("fc1_w", act_w, e.val);
      end else begin
        check_val("fc1_w_zero", act_w, 0);
      end
      if (wmem_rd_en) begin
        if (rd_q.size() == 0) begin
          check_val("rd_unexpected", wmem_addr, 64'hFFFF);
        end else begin
          e = rd_q.pop_front();
          check_val("rd_addr", wmem_addr, e.val);
          check_val("rd_cycle", cyc, e.cyc);
          if (e.val < FC2_A) w_q.push_back('{e.cyc + 1, int'(mem_word(e.val))});
        end
      end
      if (fc1_next) begin
        if (prev_next) check_val("next_back_to_back", 1, 0);
        if (nx_q.size() == 0) begin
          check_val("next_unexpected", cyc, 0);
        end else begin
          np = nx_q.pop_front();
          check_val("next_cycle", cyc, np);
        end
      end
      prev_next = fc1_next;
    end
  end

  task automatic check_reset();
    logic [31:0] w;
    for (int k = 0; k < NUM_PE; k++) w[8*k +: 8] = fc1_w[k];
    check_val("rst_rd_en", wmem_rd_en, 0);
    check_val("rst_addr", wmem_addr, 0);
    check_val("rst_next", fc1_next, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_group", group_idx, 0);
    check_val("rst_perr", proto_err, 0);
    check_val("rst_fc1_w", w, 0);
    for (int m = 0; m < OUT1_M; m++) check_val("rst_fc2_w", fc2_w[m], 0);
  endtask

  // One full run: three FC1 groups, FC2 preload, final release, start drop.
  task automatic run(input int hold, input bit spurious);
    int s, v, p;
    @(posedge clk); #1;
    s = cyc;
    p = s;
    start = 1'b1;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < IN1_N; i++) rd_q.push_back('{s + 1 + i, g * IN1_N + i});
      if (g == 1) begin
        wait_to(s + 5);
        check_val("group_idx_1", group_idx, 1);
      end
      if (spurious && g == 0) begin
        wait_to(s + 20);
        fc1_valid = 1'b1;
        perr_exp = 1'b1;
        wait_to(s + 21);
        fc1_valid = 1'b0;
        wait_to(s + 22);
        check_val("perr_set", proto_err, 1);
      end
      v = s + IN1_N + 2;
      wait_to(v);
      fc1_valid = 1'b1;
      if (hold > 0) hold_next = 1'b1;
      if (g == 2) begin
        for (int j = 0; j < 3; j++) rd_q.push_back('{v + 1 + j, FC2_A + j});
        p = (v + 1 + hold > v + 5) ? v + 1 + hold : v + 5;
      end else begin
        p = v + 1 + hold;
      end
      nx_q.push_back(p);
      wait_to(v + 1);
      fc1_valid = 1'b0;
      if (hold > 0) begin
        wait_to(v + 1 + hold);
        hold_next = 1'b0;
      end
      s = p;
    end
    wait_to(p + 4);
    check_val("end_busy_start_held", busy, 1);
    check_val("end_group_idx", group_idx, 2);
    check_val("end_perr", proto_err, perr_exp);
    check_val("reads_left", rd_q.size(), 0);
    check_val("next_left", nx_q.size(), 0);
    check_val("w_left", w_q.size(), 0);
    for (int m = 0; m < OUT1_M; m++) check_val("fc2_w", fc2_w[m], m + 1);
    start = 1'b0;
    wait_to(p + 6);
    check_val("idle_busy", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; fc1_valid = 1'b0; hold_next = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(0, 1'b0);
    run(7, 1'b1);

    // Reset pulsed while read i=50 of group 0 is on the bus.
    begin
      int s;
      @(posedge clk); #1;
      s = cyc;
      start = 1'b1;
      for (int i = 0; i < IN1_N; i++) rd_q.push_back('{s + 1 + i, i});
      wait_to(s + 51);
      rd_q.delete();
      w_q.delete();
      nx_q.delete();
      perr_exp = 1'b0;
      rst_n = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
    end

    run(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
